// File: rtl/sseg_pattern_decoder.sv
// rtl/sseg_pattern_decoder.sv - 7-segment pattern stabiliser, hex decoder and step classifier
module sseg_pattern_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sseg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] digit,
  output logic       dp,
  output logic       step_up,
  output logic       step_down,
  output logic       jump,
  output logic       first,
  output logic       err_invalid,
  output logic [7:0] err_count
);

  typedef enum logic {SETTLE, EMIT} state_t;

  localparam logic [7:0] STAB_TH = 8'(STABLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_s_q;
  logic [7:0] r_stab;
  logic [7:0] r_last_pat;
  logic       r_last_set;
  logic       r_have_prev;
  logic [3:0] r_prev_digit;
  logic [3:0] r_digit;
  logic       r_dp;
  logic       r_step_up;
  logic       r_step_down;
  logic       r_jump;
  logic       r_first;
  logic       r_err_invalid;
  logic [7:0] r_err_count;

  logic       w_valid;
  logic [3:0] w_digit;
  logic       w_new;
  logic       w_accept;
  logic       w_reject;
  logic [3:0] w_delta;

  // Map the seven segment bits (dp ignored) back to a hex digit
  always_comb begin
    w_valid = 1'b1;
    w_digit = 4'h0;
    case (r_s_q[7:1])
      7'h7E: w_digit = 4'h0;
      7'h30: w_digit = 4'h1;
      7'h6D: w_digit = 4'h2;
      7'h79: w_digit = 4'h3;
      7'h33: w_digit = 4'h4;
      7'h5B: w_digit = 4'h5;
      7'h5F: w_digit = 4'h6;
      7'h70: w_digit = 4'h7;
      7'h7F: w_digit = 4'h8;
      7'h7B: w_digit = 4'h9;
      7'h77: w_digit = 4'hA;
      7'h1F: w_digit = 4'hB;
      7'h0D: w_digit = 4'hC;
      7'h3D: w_digit = 4'hD;
      7'h4F: w_digit = 4'hE;
      7'h47: w_digit = 4'hF;
      default: w_valid = 1'b0;
    endcase
  end

  // last_set is kept apart from have_prev so an invalid pattern seen before any
  // valid digit is still reported only once
  assign w_new    = (r_stab >= STAB_TH) && (!r_last_set || (r_s_q != r_last_pat));
  assign w_accept = (r_state == SETTLE) && w_new && w_valid;
  assign w_reject = (r_state == SETTLE) && w_new && !w_valid;
  assign w_delta  = w_digit - r_prev_digit;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= SETTLE;
    else      r_state <= w_next;
  end

  // Next state: accept a stable valid pattern, return after the handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      SETTLE:  if (w_accept)  w_next = EMIT;
      EMIT:    if (out_ready) w_next = SETTLE;
      default: w_next = SETTLE;
    endcase
  end

  // Sample the bus and count consecutive identical samples (saturating)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_q  <= 8'h00;
      r_stab <= 8'h00;
    end else begin
      r_s_q <= sseg_in;
      if (sseg_in == r_s_q) r_stab <= (r_stab == 8'hFF) ? 8'hFF : r_stab + 8'd1;
      else                  r_stab <= 8'h00;
    end
  end

  // Load the result on acceptance; count and remember invalid patterns
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_pat    <= 8'h00;
      r_last_set    <= 1'b0;
      r_have_prev   <= 1'b0;
      r_prev_digit  <= 4'h0;
      r_digit       <= 4'h0;
      r_dp          <= 1'b0;
      r_step_up     <= 1'b0;
      r_step_down   <= 1'b0;
      r_jump        <= 1'b0;
      r_first       <= 1'b0;
      r_err_invalid <= 1'b0;
      r_err_count   <= 8'h00;
    end else begin
      r_err_invalid <= w_reject;
      if (w_accept) begin
        r_digit      <= w_digit;
        r_dp         <= r_s_q[0];
        r_first      <= !r_have_prev;
        r_step_up    <= r_have_prev && (w_delta == 4'h1);
        r_step_down  <= r_have_prev && (w_delta == 4'hF);
        r_jump       <= r_have_prev && (w_delta != 4'h1) && (w_delta != 4'hF);
        r_last_pat   <= r_s_q;
        r_last_set   <= 1'b1;
        r_have_prev  <= 1'b1;
        r_prev_digit <= w_digit;
      end
      if (w_reject) begin
        r_last_pat <= r_s_q;
        r_last_set <= 1'b1;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign out_valid   = (r_state == EMIT);
  assign digit       = r_digit;
  assign dp          = r_dp;
  assign step_up     = r_step_up;
  assign step_down   = r_step_down;
  assign jump        = r_jump;
  assign first       = r_first;
  assign err_invalid = r_err_invalid;
  assign err_count   = r_err_count;

endmodule
